// File: rtl/operand_feeder.sv
// Edge-of-array operand transmitter: buffers one row/column from the host and streams it
// into a PE over the waiting/ready/finished handshake. Optional start skew: FEEDER_SKEW_EN.
module operand_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int SKEW       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    input  logic                  clear,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_waiting,
    input  logic                  out_ready,
    output logic                  out_finished
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SKEW < 0) begin : g_param_check
        $error("operand_feeder: DEPTH must be a power of two >= 2 and SKEW >= 0");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
`ifdef FEEDER_SKEW_EN
        , SKEW_WAIT
`endif
    } state_t;

    state_t                state_reg, state_next;
    logic [AW:0]           count_reg, count_next;
    logic [AW-1:0]         idx_reg, idx_next;
    logic                  waiting_reg, waiting_next;
    logic                  finished_reg, finished_next;
    logic                  done_reg, done_next;
    logic                  busy_reg;
    logic                  full_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic                  wr_go;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef FEEDER_SKEW_EN
    localparam int SKW = (SKEW > 1) ? $clog2(SKEW) : 1;
    logic [SKW-1:0] skew_reg, skew_next;
`endif

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        idx_next      = idx_reg;
        waiting_next  = waiting_reg;
        finished_next = finished_reg;
        done_next     = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = idx_reg;
        wr_go         = 1'b0;
`ifdef FEEDER_SKEW_EN
        skew_next     = skew_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    count_next = '0;
                end else if (start) begin
                    idx_next = '0;
                    if (count_reg == '0) begin
                        state_next    = FINISH;
                        finished_next = 1'b1;
                    end else
`ifdef FEEDER_SKEW_EN
                    if (SKEW > 0) begin
                        state_next = SKEW_WAIT;
                        skew_next  = '0;
                    end else
`endif
                    begin
                        state_next   = SEND;
                        waiting_next = 1'b1;
                        rd_en        = 1'b1;
                        rd_addr      = '0;
                    end
                end else if (wr_en && !full_reg) begin
                    wr_go      = 1'b1;
                    count_next = count_reg + (AW+1)'(1);
                end
            end
`ifdef FEEDER_SKEW_EN
            SKEW_WAIT: begin
                if (skew_reg == SKW'(SKEW - 1)) begin
                    state_next   = SEND;
                    waiting_next = 1'b1;
                    rd_en        = 1'b1;
                    rd_addr      = '0;
                end else begin
                    skew_next = skew_reg + SKW'(1);
                end
            end
`endif
            SEND: begin
                // A transfer happens on this edge; pre-fetch the next element or finish.
                if (out_ready) begin
                    if ({1'b0, idx_reg} == count_reg - (AW+1)'(1)) begin
                        state_next    = FINISH;
                        waiting_next  = 1'b0;
                        finished_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + AW'(1);
                        rd_en    = 1'b1;
                        rd_addr  = idx_reg + AW'(1);
                    end
                end
            end
            FINISH: begin
                if (out_ready) begin
                    state_next    = IDLE;
                    finished_next = 1'b0;
                    done_next     = 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                waiting_next  = 1'b0;
                finished_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            idx_reg      <= '0;
            waiting_reg  <= 1'b0;
            finished_reg <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            full_reg     <= 1'b0;
`ifdef FEEDER_SKEW_EN
            skew_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            idx_reg      <= idx_next;
            waiting_reg  <= waiting_next;
            finished_reg <= finished_next;
            done_reg     <= done_next;
            busy_reg     <= (state_next != IDLE);
            full_reg     <= (count_next == (AW+1)'(DEPTH));
`ifdef FEEDER_SKEW_EN
            skew_reg     <= skew_next;
`endif
        end
    end

    // Buffer storage is never reset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (rst && wr_go) begin
            mem[count_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg <= '0;
        end else if (rd_en) begin
            data_reg <= mem[rd_addr];
        end
    end

    assign wr_full      = full_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign out_data     = data_reg;
    assign out_waiting  = waiting_reg;
    assign out_finished = finished_reg;
endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: directed scenarios plus randomized rounds checked
// against a queue model of the buffer. Skew scenario is built when FEEDER_SKEW_EN is defined.
module tb_operand_feeder;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
`ifdef FEEDER_SKEW_EN
    localparam int SKEW  = 3;
`else
    localparam int SKEW  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          wr_full, busy, done, out_waiting, out_finished;
    logic [DW-1:0] out_data;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] got_q[$];
    int            stall_err, cycles;
    bit            fin_seen, done_at_fin, busy_at_fin;

    operand_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW(SKEW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .clear(clear), .start(start), .busy(busy), .done(done), .out_data(out_data),
        .out_waiting(out_waiting), .out_ready(out_ready), .out_finished(out_finished)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_val(input logic [DW-1:0] v);
        wr_en = 1'b1; wr_data = v;
        tick();
        wr_en = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(v);
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        model_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    // Plays the PE side: records accepted elements and counts handshake-rule violations.
    task automatic collect(input int mode);
        bit rdy, pw, pf;
        logic [DW-1:0] pd;
        got_q.delete();
        stall_err = 0; cycles = 0; fin_seen = 0; done_at_fin = 0; busy_at_fin = 1;
        for (int c = 0; c < 400 && !fin_seen; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 3 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            out_ready = rdy; pw = out_waiting; pf = out_finished; pd = out_data;
            tick(); cycles++;
            if (out_waiting && out_finished) stall_err++;
            if (pw && rdy) got_q.push_back(pd);
            else if (pw && (out_waiting !== 1'b1 || out_data !== pd)) stall_err++;
            if (pf && rdy) begin
                fin_seen = 1; done_at_fin = done; busy_at_fin = busy;
            end else begin
                if (pf && out_finished !== 1'b1) stall_err++;
                if (done) stall_err++;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        n_cmp++; if (out_waiting !== 1'b0) begin n_err++; $display("FAIL reset_waiting got=%b exp=0", out_waiting); end
        n_cmp++; if (out_finished !== 1'b0) begin n_err++; $display("FAIL reset_finished got=%b exp=0", out_finished); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        n_cmp++; if (wr_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", wr_full); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data); end
        rst = 1'b1; tick();
        $display("test_reset done");
    endtask

    task automatic test_stream();
        do_clear();
        write_val(16'd3); write_val(16'd5); write_val(16'd7);
        do_start();
`ifndef FEEDER_SKEW_EN
        n_cmp++; if (out_waiting !== 1'b1 || out_data !== 16'd3) begin
            n_err++; $display("FAIL stream_first got=%b/%0d exp=1/3", out_waiting, out_data); end
`endif
        collect(0);
        n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL stream_len got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            n_cmp++; if (got_q[i] !== model_q[i]) begin n_err++; $display("FAIL stream_data[%0d] got=%0d exp=%0d", i, got_q[i], model_q[i]); end
        end
        n_cmp++; if (cycles != 3 + 1 + SKEW) begin n_err++; $display("FAIL stream_cycles got=%0d exp=%0d", cycles, 4 + SKEW); end
        n_cmp++; if (!fin_seen || done_at_fin !== 1'b1 || busy_at_fin !== 1'b0) begin
            n_err++; $display("FAIL stream_done got=fin%0d done%0d busy%0d exp=fin1 done1 busy0", fin_seen, done_at_fin, busy_at_fin); end
        n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL stream_protocol got=%0d exp=0", stall_err); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got=%b exp=0", done); end
        $display("test_stream: %0d elements in %0d cycles", got_q.size(), cycles);
    endtask

    task automatic test_stall_replay();
        for (int pass = 0; pass < 2; pass++) begin
            do_start();
            collect(pass == 0 ? 1 : 0);
            n_cmp++; if (got_q.size() != model_q.size()) begin n_err++; $display("FAIL stall_len got=%0d exp=%0d", got_q.size(), model_q.size()); end
            for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== model_q[i]) begin n_err++; $display("FAIL stall_data[%0d] got=%0d exp=%0d", i, got_q[i], model_q[i]); end
            end
            n_cmp++; if (stall_err != 0 || !fin_seen || done_at_fin !== 1'b1) begin
                n_err++; $display("FAIL stall_protocol got=err%0d fin%0d done%0d exp=err0 fin1 done1", stall_err, fin_seen, done_at_fin); end
            $display("test_stall_replay pass %0d: %0d elements", pass, got_q.size());
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < DEPTH + 2; i++) begin
            write_val(DW'($urandom));
            n_cmp++; if (wr_full !== (model_q.size() == DEPTH)) begin
                n_err++; $display("FAIL overflow_full[%0d] got=%b exp=%b", i, wr_full, model_q.size() == DEPTH); end
        end
        do_start();
        collect(2);
        n_cmp++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL overflow_len got=%0d exp=%0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            n_cmp++; if (got_q[i] !== model_q[i]) begin n_err++; $display("FAIL overflow_data[%0d] got=%h exp=%h", i, got_q[i], model_q[i]); end
        end
        $display("test_overflow: %0d elements streamed", got_q.size());
    endtask

    task automatic test_empty_and_clear();
        do_clear();
        do_start();
        n_cmp++; if (out_finished !== 1'b1 || out_waiting !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL empty_start got=fin%b wait%b busy%b exp=fin1 wait0 busy1", out_finished, out_waiting, busy); end
        collect(0);
        n_cmp++; if (got_q.size() != 0 || done_at_fin !== 1'b1) begin
            n_err++; $display("FAIL empty_stream got=len%0d done%0d exp=len0 done1", got_q.size(), done_at_fin); end
        write_val(16'h11); write_val(16'h22);
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        model_q.delete();
        n_cmp++; if (busy !== 1'b0 || out_waiting !== 1'b0 || out_finished !== 1'b0) begin
            n_err++; $display("FAIL clear_start got=busy%b wait%b fin%b exp=000", busy, out_waiting, out_finished); end
        do_start();
        n_cmp++; if (out_finished !== 1'b1 || out_waiting !== 1'b0) begin
            n_err++; $display("FAIL cleared_empty got=fin%b wait%b exp=fin1 wait0", out_finished, out_waiting); end
        collect(0);
        $display("test_empty_and_clear done");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int n;
            if ($urandom_range(0, 2) == 0) do_clear();
            n = $urandom_range(0, DEPTH + 1);
            for (int i = 0; i < n; i++) write_val(DW'($urandom));
            do_start();
            collect(2);
            n_cmp++; if (got_q.size() != model_q.size()) begin n_err++; $display("FAIL rand%0d_len got=%0d exp=%0d", r, got_q.size(), model_q.size()); end
            for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== model_q[i]) begin n_err++; $display("FAIL rand%0d_data[%0d] got=%h exp=%h", r, i, got_q[i], model_q[i]); end
            end
            n_cmp++; if (stall_err != 0 || !fin_seen || done_at_fin !== 1'b1 || busy_at_fin !== 1'b0) begin
                n_err++; $display("FAIL rand%0d_protocol got=err%0d fin%0d done%0d busy%0d exp=0 1 1 0", r, stall_err, fin_seen, done_at_fin, busy_at_fin); end
            $display("test_random round %0d: %0d elements, %0d cycles", r, got_q.size(), cycles);
        end
    endtask

`ifdef FEEDER_SKEW_EN
    task automatic test_skew();
        do_clear();
        write_val(16'hA1); write_val(16'hB2);
        do_start();
        for (int k = 0; k < SKEW; k++) begin
            n_cmp++; if (out_waiting !== 1'b0) begin n_err++; $display("FAIL skew_early[%0d] got=%b exp=0", k + 1, out_waiting); end
            tick();
        end
        n_cmp++; if (out_waiting !== 1'b1 || out_data !== 16'hA1) begin
            n_err++; $display("FAIL skew_first got=%b/%h exp=1/a1", out_waiting, out_data); end
        collect(0);
        n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL skew_len got=%0d exp=2", got_q.size()); end
        $display("test_skew done");
    endtask
`endif

    task automatic test_reset_midstream();
        int done_cnt;
        do_clear();
        for (int i = 0; i < 4; i++) write_val(DW'($urandom));
        do_start();
        out_ready = 1'b0;
        repeat (SKEW + 2) tick();
        rst = 1'b0; tick(); rst = 1'b1;
        model_q.delete();
        n_cmp++; if (out_waiting !== 1'b0 || out_finished !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midreset got=wait%b fin%b busy%b done%b exp=0000", out_waiting, out_finished, busy, done); end
        out_ready = 1'b1;
        done_cnt = 0;
        repeat (3) begin tick(); if (done) done_cnt++; end
        out_ready = 1'b0;
        n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL midreset_done got=%0d exp=0", done_cnt); end
        do_start();
        n_cmp++; if (out_finished !== 1'b1 || out_waiting !== 1'b0) begin
            n_err++; $display("FAIL midreset_count got=fin%b wait%b exp=fin1 wait0", out_finished, out_waiting); end
        collect(0);
        $display("test_reset_midstream done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_replay();
        test_overflow();
        test_empty_and_clear();
        test_random();
`ifdef FEEDER_SKEW_EN
        test_skew();
`endif
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
